ysyx_25060170_gpr_file: RTL and testbench

//  General-purpose register file at the receiving end of the WBU writeback port.

---
 rtl/ysyx_25060170_gpr_file_if.sv | 32 +++
 rtl/ysyx_25060170_gpr_file.sv | 117 +++++++++++
 tb/tb_ysyx_25060170_gpr_file.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25060170_gpr_file_if.sv
// Writeback, read-port and issue signals between the WBU/IDU side and the GPR file.
// The master modport is the pipeline side and the slave modport is the register file.
interface ysyx_25060170_gpr_file_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            wb_valid_i;
  logic            wb_ready_o;
  logic [AW-1:0]   wb_addr_i;
  logic [XLEN-1:0] wb_data_i;
  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            issue_valid_i;
  logic [AW-1:0]   issue_rd_i;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  logic [31:0]     wb_count_o;

  modport master (
    output wb_valid_i, wb_addr_i, wb_data_i, rs1_addr_i, rs2_addr_i,
           issue_valid_i, issue_rd_i,
    input  wb_ready_o, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, wb_count_o
  );

  modport slave (
    input  wb_valid_i, wb_addr_i, wb_data_i, rs1_addr_i, rs2_addr_i,
           issue_valid_i, issue_rd_i,
    output wb_ready_o, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, wb_count_o
  );
endinterface

// File: rtl/ysyx_25060170_gpr_file.sv
// GPR file: INIT sweep zeroes the array after reset, then accepts writebacks with
// same-cycle read bypass and keeps a busy scoreboard of pending destination registers.
module ysyx_25060170_gpr_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25060170_gpr_file_if.slave       bus
);

  localparam int NSLOT = 2 ** AW;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // Bit i set when register i exists and is not x0: the only addresses that store or go busy.
  function automatic logic [NSLOT-1:0] writable_mask();
    logic [NSLOT-1:0] m;
    for (int i = 0; i < NSLOT; i++) m[i] = (i != 0) && (i < NREG);
    return m;
  endfunction

  localparam logic [NSLOT-1:0] WRITABLE = writable_mask();

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            run;
  logic            accept;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem [NREG];
  logic [NSLOT-1:0] busy_q, busy_set, busy_clr;
  logic [31:0]     count_q;

  assign run            = (state_q == ST_RUN);
  assign accept         = bus.wb_valid_i & run;
  assign bus.wb_ready_o = run;
  assign bus.wb_count_o = count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_waddr = bus.wb_addr_i;
    mem_wdata = bus.wb_data_i;
    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = '0;
        idx_d     = idx_q + 1'b1;
        if (idx_q == AW'(NREG - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we = accept & WRITABLE[bus.wb_addr_i];
      end
    endcase
  end

  // NOTE: the array has no reset; the INIT sweep clears it before any read is honoured.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (run && bus.issue_valid_i) busy_set[bus.issue_rd_i] = WRITABLE[bus.issue_rd_i];
    if (accept)                   busy_clr[bus.wb_addr_i]  = WRITABLE[bus.wb_addr_i];
  end

  // Set is applied after clear: a newly issued producer outranks the retiring one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q <= (busy_q & ~busy_clr) | busy_set;
      if (accept) count_q <= count_q + 32'd1;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    if (!run || !WRITABLE[a])              return '0;
    if (accept && bus.wb_addr_i == a)      return bus.wb_data_i;
    return mem[a];
  endfunction

  function automatic logic busy_port(input logic [AW-1:0] a);
    return run & WRITABLE[a] & busy_q[a] & ~(accept & (bus.wb_addr_i == a));
  endfunction

  always_comb begin
    bus.rs1_data_o = read_port(bus.rs1_addr_i);
    bus.rs2_data_o = read_port(bus.rs2_addr_i);
    bus.rs1_busy_o = busy_port(bus.rs1_addr_i);
    bus.rs2_busy_o = busy_port(bus.rs2_addr_i);
  end

endmodule

// File: tb/tb_ysyx_25060170_gpr_file.sv
// Self-checking bench for ysyx_25060170_gpr_file: directed vector table, INIT/reset
// sequences, and randomized traffic compared against an array-based register file model.
module tb_ysyx_25060170_gpr_file;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        issue;
    logic [4:0]  rd;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic        e_b1;
    logic        e_b2;
    logic [31:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_25060170_gpr_file_if #(.XLEN(XLEN), .AW(AW)) bus ();

  ysyx_25060170_gpr_file #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain arrays plus a cycle count since reset release.
  logic [31:0] m_mem  [NREG];
  bit          m_busy [NREG];
  int          m_init;
  logic [31:0] m_count;
  stim_t       cur;
  stim_t       idle;
  vec_t        vec [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input stim_t s);
    cur               = s;
    bus.wb_valid_i    = s.valid;
    bus.wb_addr_i     = s.addr;
    bus.wb_data_i     = s.data;
    bus.rs1_addr_i    = s.rs1;
    bus.rs2_addr_i    = s.rs2;
    bus.issue_valid_i = s.issue;
    bus.issue_rd_i    = s.rd;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
  task automatic tick(input stim_t s, input bit release_rst);
    @(posedge clk);
    #1;
    if (release_rst) rst = 1'b1;
    drive(s);
    #3;
  endtask

  function automatic bit m_run();
    return m_init >= NREG;
  endfunction

  function automatic bit m_real(input logic [4:0] a);
    return (a != 0) && (int'(a) < NREG);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!m_run() || !m_real(a)) return 32'h0;
    if (cur.valid && cur.addr == a) return cur.data;
    return m_mem[a];
  endfunction

  function automatic logic m_busyf(input logic [4:0] a);
    if (!m_run() || !m_real(a)) return 1'b0;
    if (cur.valid && cur.addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic m_reset();
    m_init  = 0;
    m_count = 32'h0;
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Advance the model across the edge that ends the current cycle.
  task automatic commit();
    if (!m_run()) begin
      m_init++;
    end else begin
      if (cur.valid) begin
        m_count = m_count + 32'd1;
        if (m_real(cur.addr)) begin
          m_mem[cur.addr]  = cur.data;
          m_busy[cur.addr] = 1'b0;
        end
      end
      if (cur.issue && m_real(cur.rd)) m_busy[cur.rd] = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rs1_data"}, bus.rs1_data_o, m_read(cur.rs1));
    check({tag, ".rs2_data"}, bus.rs2_data_o, m_read(cur.rs2));
    check({tag, ".rs1_busy"}, 32'(bus.rs1_busy_o), 32'(m_busyf(cur.rs1)));
    check({tag, ".rs2_busy"}, 32'(bus.rs2_busy_o), 32'(m_busyf(cur.rs2)));
    check({tag, ".ready"},    32'(bus.wb_ready_o), 32'(m_run()));
    check({tag, ".count"},    bus.wb_count_o, m_count);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = 1'($urandom_range(0, 1));
    s.addr  = 5'($urandom_range(0, 31));
    s.data  = $urandom;
    s.rs1   = ($urandom_range(0, 3) == 0) ? s.addr : 5'($urandom_range(0, 31));
    s.rs2   = 5'($urandom_range(0, 31));
    s.issue = ($urandom_range(0, 9) < 4);
    s.rd    = ($urandom_range(0, 3) == 0) ? s.addr : 5'($urandom_range(0, 31));
    return s;
  endfunction

  function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [31:0] d,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic iv, input logic [4:0] rd,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic b1, input logic b2, input logic [31:0] cnt);
    vec_t x;
    x.s.valid = v;  x.s.addr = a;  x.s.data = d;
    x.s.rs1 = r1;   x.s.rs2 = r2;  x.s.issue = iv; x.s.rd = rd;
    x.e_rs1 = e1;   x.e_rs2 = e2;  x.e_b1 = b1;    x.e_b2 = b2; x.e_cnt = cnt;
    return x;
  endfunction

  // Releases reset and walks the whole sweep while offering writebacks and issues to x9.
  task automatic run_init(input string tag);
    stim_t s;
    for (int c = 0; c <= NREG; c++) begin
      s       = idle;
      s.valid = (c < NREG);
      s.addr  = 5'd9;
      s.data  = 32'hBAD0_0000 | 32'(c);
      s.rs1   = 5'd9;
      s.rs2   = 5'(c);
      s.issue = (c < NREG);
      s.rd    = 5'd9;
      tick(s, c == 0);
      check({tag, ".ready"},    32'(bus.wb_ready_o), (c == NREG) ? 32'd1 : 32'd0);
      check({tag, ".rs1_data"}, bus.rs1_data_o, 32'h0);
      check({tag, ".rs2_data"}, bus.rs2_data_o, 32'h0);
      check({tag, ".rs1_busy"}, 32'(bus.rs1_busy_o), 32'h0);
      check({tag, ".count"},    bus.wb_count_o, 32'h0);
      commit();
    end
  endtask

  initial begin
    stim_t s;
    idle = '{valid: 1'b0, addr: 5'd0, data: 32'h0, rs1: 5'd0, rs2: 5'd0, issue: 1'b0, rd: 5'd0};
    drive(idle);
    m_reset();
    repeat (3) @(posedge clk);

    run_init("init");

    //          v  addr   data           rs1    rs2    iss rd     e_rs1          e_rs2          b1 b2 cnt
    vec[0]  = mk(1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  0, 5'd0,  32'hDEADBEEF, 32'h0,        0, 0, 32'd0);
    vec[1]  = mk(0, 5'd0,  32'h0,        5'd5,  5'd5,  0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'd1);
    vec[2]  = mk(1, 5'd0,  32'h00001234, 5'd0,  5'd0,  0, 5'd0,  32'h0,        32'h0,        0, 0, 32'd1);
    vec[3]  = mk(0, 5'd0,  32'h0,        5'd7,  5'd5,  1, 5'd7,  32'h0,        32'hDEADBEEF, 0, 0, 32'd2);
    vec[4]  = mk(0, 5'd0,  32'h0,        5'd7,  5'd0,  0, 5'd0,  32'h0,        32'h0,        1, 0, 32'd2);
    vec[5]  = mk(1, 5'd7,  32'h00000077, 5'd7,  5'd7,  1, 5'd7,  32'h77,       32'h77,       0, 0, 32'd2);
    vec[6]  = mk(0, 5'd0,  32'h0,        5'd7,  5'd0,  0, 5'd0,  32'h77,       32'h0,        1, 0, 32'd3);
    vec[7]  = mk(1, 5'd7,  32'h00000088, 5'd7,  5'd5,  0, 5'd0,  32'h88,       32'hDEADBEEF, 0, 0, 32'd3);
    vec[8]  = mk(0, 5'd0,  32'h0,        5'd7,  5'd0,  0, 5'd0,  32'h88,       32'h0,        0, 0, 32'd4);
    vec[9]  = mk(0, 5'd0,  32'h0,        5'd0,  5'd7,  1, 5'd0,  32'h0,        32'h88,       0, 0, 32'd4);
    vec[10] = mk(0, 5'd0,  32'h0,        5'd0,  5'd31, 0, 5'd0,  32'h0,        32'h0,        0, 0, 32'd4);
    vec[11] = mk(1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31, 1, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'd4);
    vec[12] = mk(0, 5'd0,  32'h0,        5'd31, 5'd0,  0, 5'd0,  32'hFFFFFFFF, 32'h0,        1, 0, 32'd5);

    foreach (vec[i]) begin
      tick(vec[i].s, 1'b0);
      check($sformatf("vec%0d.rs1_data", i), bus.rs1_data_o, vec[i].e_rs1);
      check($sformatf("vec%0d.rs2_data", i), bus.rs2_data_o, vec[i].e_rs2);
      check($sformatf("vec%0d.rs1_busy", i), 32'(bus.rs1_busy_o), 32'(vec[i].e_b1));
      check($sformatf("vec%0d.rs2_busy", i), 32'(bus.rs2_busy_o), 32'(vec[i].e_b2));
      check($sformatf("vec%0d.ready", i),    32'(bus.wb_ready_o), 32'd1);
      check($sformatf("vec%0d.count", i),    bus.wb_count_o, vec[i].e_cnt);
      commit();
    end

    for (int i = 0; i < 400; i++) begin
      tick(rand_stim(), 1'b0);
      check_model($sformatf("rand%0d", i));
      commit();
    end

    // Leave x3 pending, then assert reset mid-cycle while a writeback is offered.
    s       = idle;
    s.issue = 1'b1;
    s.rd    = 5'd3;
    tick(s, 1'b0);
    check_model("pre_rst0");
    commit();
    s       = idle;
    s.valid = 1'b1;
    s.addr  = 5'd4;
    s.data  = 32'h0BAD_F00D;
    s.rs1   = 5'd3;
    s.rs2   = 5'd4;
    tick(s, 1'b0);
    check_model("pre_rst1");
    rst = 1'b0;
    #1;
    check("rst.count",    bus.wb_count_o, 32'h0);
    check("rst.rs1_busy", 32'(bus.rs1_busy_o), 32'h0);
    check("rst.ready",    32'(bus.wb_ready_o), 32'h0);
    check("rst.rs2_data", bus.rs2_data_o, 32'h0);
    m_reset();
    @(posedge clk);
    #2;
    check("rst_hold.count", bus.wb_count_o, 32'h0);

    run_init("reinit");

    for (int i = 0; i < NREG / 2; i++) begin
      s     = idle;
      s.rs1 = 5'(2 * i);
      s.rs2 = 5'(2 * i + 1);
      tick(s, 1'b0);
      check_model($sformatf("sweep%0d", i));
      commit();
    end

    for (int i = 0; i < 100; i++) begin
      tick(rand_stim(), 1'b0);
      check_model($sformatf("rand_b%0d", i));
      commit();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
